bus_tenure_scheduler: RTL and testbench

Sequences ownership of the shared bus between NUMUNITS requesters.
- Grants one requester at a time and holds the grant for a full transaction tenure.
- Ends a tenure on owner completion, owner withdrawal, or a maximum-tenure timeout.
- Inserts a one-cycle turnaround between owners.
- Selects the next owner by round-robin or by lowest programmed priority, with round-robin tie-break.

---
 rtl/bus_tenure_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_bus_tenure_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_tenure_scheduler.sv
// Shared-bus ownership sequencer: grants one requester per tenure, ends tenures on
// done, withdrawal or timeout, and inserts one turnaround cycle between owners.
module bus_tenure_scheduler #(
   parameter int NUMUNITS     = 8,
   parameter int ADDRESSWIDTH = 3,
   parameter int MAXTENURE    = 16,
   parameter int TENUREWIDTH  = 5
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             roundORpriority,
   input  logic [NUMUNITS-1:0]              request,
   input  logic [ADDRESSWIDTH*NUMUNITS-1:0] priorit,
   input  logic [NUMUNITS-1:0]              done,
   output logic [NUMUNITS-1:0]              grant,
   output logic [ADDRESSWIDTH-1:0]          grant_id,
   output logic                             busy,
   output logic                             tenure_expired
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      TURN = 2'd2
   } state_t;

   localparam logic [TENUREWIDTH-1:0] TENURE_LAST = TENUREWIDTH'(MAXTENURE - 1);
   localparam logic [TENUREWIDTH-1:0] TENURE_SAT  = TENUREWIDTH'(MAXTENURE);

   state_t                  state;
   state_t                  state_nx;
   logic [ADDRESSWIDTH-1:0] next_ptr;
   logic [ADDRESSWIDTH-1:0] next_ptr_nx;
   logic [ADDRESSWIDTH-1:0] grant_id_nx;
   logic [NUMUNITS-1:0]     grant_nx;
   logic                    busy_nx;
   logic                    expired_nx;
   logic [TENUREWIDTH-1:0]  count;
   logic [TENUREWIDTH-1:0]  count_nx;

   logic [ADDRESSWIDTH-1:0] min_pri;
   logic [NUMUNITS-1:0]     candidates;
   logic [ADDRESSWIDTH-1:0] winner;
   logic [ADDRESSWIDTH-1:0] pick;
   logic                    hit;
   logic                    found;

   logic                    any_request;
   logic                    owner_done;
   logic                    owner_req;
   logic [NUMUNITS-1:0]     others;
   logic                    timeout;
   logic                    tenure_end;

   function automatic logic [ADDRESSWIDTH-1:0] pri_of(
      input logic [ADDRESSWIDTH*NUMUNITS-1:0] p,
      input int                               i
   );
      return p[i*ADDRESSWIDTH +: ADDRESSWIDTH];
   endfunction

   function automatic logic [ADDRESSWIDTH-1:0] unit_at(
      input logic [ADDRESSWIDTH-1:0] base,
      input int                      offset
   );
      int sum;
      sum = int'(base) + offset;
      if (sum >= NUMUNITS) begin
         sum = sum - NUMUNITS;
      end else begin
         sum = sum;
      end
      return ADDRESSWIDTH'(sum);
   endfunction

   function automatic logic [ADDRESSWIDTH-1:0] wrap_inc(input logic [ADDRESSWIDTH-1:0] u);
      return unit_at(u, 1);
   endfunction

   function automatic logic [NUMUNITS-1:0] onehot(input logic [ADDRESSWIDTH-1:0] u);
      return {{(NUMUNITS-1){1'b0}}, 1'b1} << u;
   endfunction

   assign any_request = |request;
   assign owner_done  = done[grant_id];
   assign owner_req   = request[grant_id];
   assign others      = request & ~grant;
   assign timeout     = (count >= TENURE_LAST) & (|others);
   assign tenure_end  = owner_done | ~owner_req | timeout;

   // Lowest priority value among units that are actually requesting.
   always_comb begin
      min_pri = {ADDRESSWIDTH{1'b1}};
      for (int i = 0; i < NUMUNITS; i++) begin
         min_pri = (request[i] && (pri_of(priorit, i) < min_pri)) ? pri_of(priorit, i) : min_pri;
      end
   end

   // Eligible set: every requester in round-robin mode, only minimum-priority ones otherwise.
   always_comb begin
      candidates = {NUMUNITS{1'b0}};
      for (int i = 0; i < NUMUNITS; i++) begin
         candidates[i] = request[i] & (~roundORpriority | (pri_of(priorit, i) == min_pri));
      end
   end

   // First eligible unit scanning upward from the next pointer with wraparound.
   always_comb begin
      winner = next_ptr;
      pick   = {ADDRESSWIDTH{1'b0}};
      hit    = 1'b0;
      found  = 1'b0;
      for (int k = 0; k < NUMUNITS; k++) begin
         pick   = unit_at(next_ptr, k);
         hit    = ~found & candidates[pick];
         winner = hit ? pick : winner;
         found  = found | hit;
      end
   end

   // Next-state and next-output decode for the IDLE/OWN/TURN sequencer.
   always_comb begin
      state_nx    = state;
      grant_nx    = grant;
      grant_id_nx = grant_id;
      busy_nx     = busy;
      expired_nx  = 1'b0;
      next_ptr_nx = next_ptr;
      count_nx    = count;
      case (state)
         IDLE, TURN: begin
            if (any_request) begin
               state_nx    = OWN;
               grant_nx    = onehot(winner);
               grant_id_nx = winner;
               busy_nx     = 1'b1;
               count_nx    = {TENUREWIDTH{1'b0}};
            end else begin
               state_nx    = IDLE;
               grant_nx    = {NUMUNITS{1'b0}};
               busy_nx     = 1'b0;
            end
         end
         OWN: begin
            if (tenure_end) begin
               state_nx    = TURN;
               grant_nx    = {NUMUNITS{1'b0}};
               busy_nx     = 1'b0;
               next_ptr_nx = wrap_inc(grant_id);
               count_nx    = {TENUREWIDTH{1'b0}};
               // Pulse only when the timeout alone ended the tenure.
               expired_nx  = timeout & ~owner_done & owner_req;
            end else begin
               count_nx    = (count >= TENURE_SAT) ? count : count + TENUREWIDTH'(1);
            end
         end
         default: begin
            state_nx    = IDLE;
            grant_nx    = {NUMUNITS{1'b0}};
            busy_nx     = 1'b0;
         end
      endcase
   end

   // State, pointer, counter and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         grant          <= {NUMUNITS{1'b0}};
         grant_id       <= {ADDRESSWIDTH{1'b0}};
         busy           <= 1'b0;
         tenure_expired <= 1'b0;
         next_ptr       <= {ADDRESSWIDTH{1'b0}};
         count          <= {TENUREWIDTH{1'b0}};
      end else begin
         state          <= state_nx;
         grant          <= grant_nx;
         grant_id       <= grant_id_nx;
         busy           <= busy_nx;
         tenure_expired <= expired_nx;
         next_ptr       <= next_ptr_nx;
         count          <= count_nx;
      end
   end

endmodule

// File: tb/tb_bus_tenure_scheduler.sv
// Self-checking bench for bus_tenure_scheduler: vector table, multi-cycle corner
// sequences and randomized traffic compared against a behavioural ownership model.
module tb_bus_tenure_scheduler;

   localparam int N    = 8;
   localparam int AW   = 3;
   localparam int MAXT = 16;
   localparam int TW   = 5;
   localparam logic [AW*N-1:0] PRI = 24'b111_000_011_000_101_000_010_000;

   logic          clk = 1'b0;
   logic          rst;
   logic          mode;
   logic [N-1:0]  request;
   logic [AW*N-1:0] priorit;
   logic [N-1:0]  done;
   logic [N-1:0]  grant;
   logic [AW-1:0] grant_id;
   logic          busy;
   logic          tenure_expired;

   int   n_pass  = 0;
   int   n_total = 0;

   // model: owner index (-1 = nobody), cycles owned so far, next start, last owner
   int   m_owner;
   int   m_held;
   int   m_next;
   int   m_last;
   logic m_exp;

   typedef struct {
      logic [N-1:0]  req;
      logic [N-1:0]  dn;
      logic          md;
      logic [N-1:0]  g;
      logic [AW-1:0] id;
      logic          b;
      logic          x;
   } vec_t;

   vec_t tbl[20];

   always #5 clk = ~clk;

   bus_tenure_scheduler #(
      .NUMUNITS(N), .ADDRESSWIDTH(AW), .MAXTENURE(MAXT), .TENUREWIDTH(TW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .roundORpriority(mode),
      .request(request),
      .priorit(priorit),
      .done(done),
      .grant(grant),
      .grant_id(grant_id),
      .busy(busy),
      .tenure_expired(tenure_expired)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
   endtask

   function automatic int pick_next(input logic [N-1:0] r, input logic md,
                                    input logic [AW*N-1:0] p, input int nx);
      int mn = 1 << AW;
      int idx;
      for (int i = 0; i < N; i++)
         if (r[i] && int'(p[i*AW +: AW]) < mn) mn = int'(p[i*AW +: AW]);
      for (int k = 0; k < N; k++) begin
         idx = (nx + k) % N;
         if (r[idx] && (!md || int'(p[idx*AW +: AW]) == mn)) return idx;
      end
      return -1;
   endfunction

   task automatic model_step();
      logic [N-1:0] mine;
      logic quit_done, quit_req, expire;
      m_exp = 1'b0;
      if (rst) begin
         m_owner = -1; m_held = 0; m_next = 0; m_last = 0;
      end else if (m_owner >= 0) begin
         mine      = N'(1) << m_owner;
         quit_done = done[m_owner];
         quit_req  = !request[m_owner];
         expire    = (m_held >= MAXT) && ((request & ~mine) != '0);
         if (quit_done || quit_req || expire) begin
            m_exp   = expire && !quit_done && !quit_req;
            m_next  = (m_owner + 1) % N;
            m_owner = -1;
         end else begin
            m_held++;
         end
      end else if (request != '0) begin
         m_owner = pick_next(request, mode, priorit, m_next);
         m_last  = m_owner;
         m_held  = 1;
      end
   endtask

   task automatic cycle();
      logic [31:0] eg;
      @(posedge clk);
      #1;
      model_step();
      eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
      chk("model_grant", 32'(grant), eg);
      chk("model_grant_id", 32'(grant_id), 32'(m_last));
      chk("model_busy", 32'(busy), (m_owner >= 0) ? 32'd1 : 32'd0);
      chk("model_expired", 32'(tenure_expired), 32'(m_exp));
   endtask

   task automatic do_reset();
      rst = 1'b1; request = '0; done = '0; mode = 1'b0; priorit = PRI;
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int owned, held, pulses;
      rst = 1'b1; mode = 1'b0; request = '0; done = '0; priorit = PRI;
      m_owner = -1; m_held = 0; m_next = 0; m_last = 0; m_exp = 1'b0;

      tbl[0]  = '{8'h04, 8'h00, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0};
      tbl[1]  = '{8'h25, 8'h04, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0};
      tbl[2]  = '{8'h25, 8'h00, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
      tbl[3]  = '{8'h25, 8'h20, 1'b0, 8'h00, 3'd5, 1'b0, 1'b0};
      tbl[4]  = '{8'h05, 8'h00, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
      tbl[5]  = '{8'h04, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
      tbl[6]  = '{8'h00, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
      tbl[7]  = '{8'h00, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
      tbl[8]  = '{8'h02, 8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0};
      tbl[9]  = '{8'h02, 8'h01, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0};
      tbl[10] = '{8'h00, 8'h00, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0};
      tbl[11] = '{8'h10, 8'h00, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
      tbl[12] = '{8'h10, 8'h10, 1'b0, 8'h00, 3'd4, 1'b0, 1'b0};
      tbl[13] = '{8'h52, 8'h00, 1'b1, 8'h40, 3'd6, 1'b1, 1'b0};
      tbl[14] = '{8'h52, 8'h40, 1'b1, 8'h00, 3'd6, 1'b0, 1'b0};
      tbl[15] = '{8'h52, 8'h00, 1'b1, 8'h10, 3'd4, 1'b1, 1'b0};
      tbl[16] = '{8'h52, 8'h10, 1'b1, 8'h00, 3'd4, 1'b0, 1'b0};
      tbl[17] = '{8'h52, 8'h00, 1'b1, 8'h40, 3'd6, 1'b1, 1'b0};
      tbl[18] = '{8'h52, 8'h40, 1'b0, 8'h00, 3'd6, 1'b0, 1'b0};
      tbl[19] = '{8'h52, 8'h00, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0};

      cycle();
      cycle();
      chk("reset_grant", 32'(grant), 32'd0);
      chk("reset_grant_id", 32'(grant_id), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_expired", 32'(tenure_expired), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         request = tbl[i].req; done = tbl[i].dn; mode = tbl[i].md;
         cycle();
         chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(tbl[i].g));
         chk($sformatf("vec%0d_grant_id", i), 32'(grant_id), 32'(tbl[i].id));
         chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].b));
         chk($sformatf("vec%0d_expired", i), 32'(tenure_expired), 32'(tbl[i].x));
      end

      // all units requesting, owners finish at once: 0..7,0 with one gap cycle each
      do_reset();
      request = 8'hFF; done = 8'hFF;
      for (int k = 0; k <= 8; k++) begin
         cycle();
         chk("rr_grant", 32'(grant), 32'd1 << (k % 8));
         chk("rr_grant_id", 32'(grant_id), 32'(k % 8));
         cycle();
         chk("rr_gap", 32'(grant), 32'd0);
      end

      // timeout: unit 0 holds, unit 3 waits
      do_reset();
      request = 8'h01;
      cycle();
      owned = (grant == 8'h01) ? 1 : 0;
      request = 8'h09;
      for (int t = 0; t < 40; t++) begin
         cycle();
         if (grant == 8'h01) owned++;
         else break;
      end
      chk("timeout_owned_cycles", 32'(owned), 32'd16);
      chk("timeout_gap_grant", 32'(grant), 32'd0);
      chk("timeout_pulse", 32'(tenure_expired), 32'd1);
      cycle();
      chk("timeout_next_grant", 32'(grant), 32'h08);
      chk("timeout_pulse_once", 32'(tenure_expired), 32'd0);

      // sole requester keeps the bus indefinitely
      do_reset();
      request = 8'h01;
      held = 0; pulses = 0;
      for (int t = 0; t < 40; t++) begin
         cycle();
         if (grant == 8'h01) held++;
         if (tenure_expired) pulses++;
      end
      chk("sole_held_cycles", 32'(held), 32'd40);
      chk("sole_no_pulse", 32'(pulses), 32'd0);

      // asynchronous reset in the middle of a tenure
      rst = 1'b1;
      #2;
      chk("async_rst_grant", 32'(grant), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_grant_id", 32'(grant_id), 32'd0);
      request = 8'h81; mode = 1'b0;
      cycle();
      rst = 1'b0;
      cycle();
      chk("post_rst_grant", 32'(grant), 32'h01);
      chk("post_rst_grant_id", 32'(grant_id), 32'd0);

      // randomized traffic against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 9) == 0) begin
            case ($urandom_range(0, 3))
               0:       request = '0;
               1:       request = N'(1) << $urandom_range(0, N - 1);
               default: request = N'($urandom);
            endcase
         end
         done = N'($urandom) & N'($urandom) & N'($urandom) & N'($urandom);
         if ($urandom_range(0, 15) == 0) mode = ~mode;
         if ($urandom_range(0, 15) == 0) priorit = (AW*N)'($urandom);
         rst = ($urandom_range(0, 399) == 0);
         cycle();
      end
      rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
